// File: rtl/test_hu_mul_arb_pkg.sv
// ---------------------------------------------------------------------------
// test_hu_mul_arb_pkg
// Shared constants, helper function and tag type for the Hu-moment
// multiplier arbiter.
//   A_W / B_W / P_W : operand a, operand b and product widths
//   ID_MAX_W        : id field width able to hold any supported NREQ (<= 8)
//   id_w(n)         : requester-id width for n requesters (at least 1)
//   tag_t           : {valid, id} record carried alongside each core operation
// ---------------------------------------------------------------------------
package test_hu_mul_arb_pkg;

  localparam int A_W      = 16;
  localparam int B_W      = 8;
  localparam int P_W      = 24;
  localparam int ID_MAX_W = 3;

  function automatic int id_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/test_hu_mul_tag_pipe.sv
// ---------------------------------------------------------------------------
// test_hu_mul_tag_pipe
// DEPTH-stage shift register of {valid, id} tags that runs in lockstep with
// the shared multiplier core. Only the valid bits are reset; the ids are
// don't-care whenever their valid bit is low.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   ce_i         : shift enable (same enable as the multiplier core)
//   tag_i        : tag entering stage 0
//   tag_o        : tag at the last stage
//   any_valid_o  : OR of all stage valid bits
// ---------------------------------------------------------------------------
module test_hu_mul_tag_pipe
  import test_hu_mul_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_i,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic any_valid_o
);

  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    valid_d;
  logic [ID_MAX_W-1:0] id_q [DEPTH];
  logic [ID_MAX_W-1:0] id_d [DEPTH];

  // Each stage takes the previous stage's tag; stage 0 takes the new tag.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign valid_d[gi] = tag_i.valid;
      assign id_d[gi]    = tag_i.id;
    end else begin : g_rest
      assign valid_d[gi] = valid_q[gi-1];
      assign id_d[gi]    = id_q[gi-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (ce_i) begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ce_i) begin
      id_q <= id_d;
    end
  end

  assign tag_o.valid = valid_q[DEPTH-1];
  assign tag_o.id    = id_q[DEPTH-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/test_hu_mul_arbiter.sv
// ---------------------------------------------------------------------------
// test_hu_mul_arbiter
// Round-robin arbiter sharing one pipelined 16x8 unsigned multiplier core
// among NREQ requesters. At most one operand pair is issued per cycle; a tag
// pipe records the owner of every in-flight product. Result backpressure
// stalls the core and the tag pipe together through mul_ce.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot or 0)
//   req_a, req_b         : packed per-requester operands (16 / 8 bits each)
//   mul_ce               : clock enable to the shared core
//   mul_din0, mul_din1   : operands to the core (0 when nothing is issued)
//   mul_dout             : product from the core, MUL_LAT enabled edges later
//   res_valid/res_ready  : result handshake
//   res_id, res_data     : owning requester and product
//   busy                 : any valid tag in flight or at the output
// ---------------------------------------------------------------------------
module test_hu_mul_arbiter
  import test_hu_mul_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*A_W-1:0]    req_a,
  input  logic [NREQ*B_W-1:0]    req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic                   res_valid,
  output logic [id_w(NREQ)-1:0]  res_id,
  output logic [P_W-1:0]         res_data,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int IDW = id_w(NREQ);

  logic [A_W-1:0] a_slice [NREQ];
  logic [B_W-1:0] b_slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_slice[gi] = req_a[gi*A_W +: A_W];
    assign b_slice[gi] = req_b[gi*B_W +: B_W];
  end

  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;
  logic           stall;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic           xfer;
  tag_t           tag_in;
  tag_t           tag_out;
  logic           tag_id_unused;

  assign stall  = res_valid & ~res_ready;
  assign mul_ce = ~stall;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  // No grant while stalled, and none while reset is held so that no
  // requester believes it handed over an operation that is being discarded.
  assign xfer = grant_found & mul_ce & ~reset;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign mul_din0 = xfer ? a_slice[grant_id] : '0;
  assign mul_din1 = xfer ? b_slice[grant_id] : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign tag_in.valid = xfer;
  assign tag_in.id    = ID_MAX_W'(grant_id);

  test_hu_mul_tag_pipe #(
    .DEPTH (MUL_LAT)
  ) u_tag_pipe (
    .clk         (clk),
    .reset       (reset),
    .ce_i        (mul_ce),
    .tag_i       (tag_in),
    .tag_o       (tag_out),
    .any_valid_o (busy)
  );

  assign res_valid = tag_out.valid;
  assign res_id    = tag_out.id[IDW-1:0];
  assign res_data  = mul_dout;

  // Upper id bits are always zero for small NREQ.
  assign tag_id_unused = ^tag_out.id;

endmodule

// File: tb/tb_test_hu_mul_arbiter.sv
module tb_test_hu_mul_arbiter;
  import test_hu_mul_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*16-1:0]  req_a;
  logic [NREQ*8-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic                mul_ce;
  logic [15:0]         mul_din0;
  logic [7:0]          mul_din1;
  logic [23:0]         mul_dout;
  logic                res_valid;
  logic [1:0]          res_id;
  logic [23:0]         res_data;
  logic                res_ready;
  logic                busy;

  int checks = 0;
  int errors = 0;

  test_hu_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy)
  );

  // Behavioural multiplier core: LAT enabled edges from capture to output.
  logic [23:0] core_q [LAT];
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      core_q[0] <= mul_din0 * mul_din1;
      for (int s = 1; s < LAT; s++) core_q[s] <= core_q[s-1];
    end
  end
  assign mul_dout = core_q[LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // One cycle: drive just after the edge, leave outputs to settle to mid-cycle.
  task automatic cyc(input logic [3:0] v, input logic r);
    @(posedge clk);
    #1;
    req_valid = v;
    res_ready = r;
    #4;
  endtask

  task automatic do_reset();
    req_valid = '0;
    res_ready = 1'b1;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_stream_operands();
    req_a = {16'd4, 16'd3, 16'd2, 16'd1};
    req_b = {8'd3, 8'd3, 8'd3, 8'd3};
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        rdy;
    logic [3:0]  e_ready;
    logic        e_ce;
    logic        e_rv;
    logic [1:0]  e_id;
    logic [23:0] e_data;
    logic        e_busy;
  } vec_t;

  vec_t tbl [25];

  initial begin
    int          got;
    logic [8:0]  rv_pat;
    logic [8:0]  busy_pat;

    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    #3;
    chk("rst res_valid", res_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst mul_ce", mul_ce, 1);
    chk("rst mul_din0", mul_din0, 0);
    chk("rst mul_din1", mul_din1, 0);

    // ---- table: continuous stream (rows 0-11) and backpressure (12-24) ----
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0, 24'd0,  1'b0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 1'b0, 2'd0, 24'd0,  1'b1};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 1'b0, 2'd0, 24'd0,  1'b1};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 2'd0, 24'd3,  1'b1};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 2'd1, 24'd6,  1'b1};
    tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 1'b1, 2'd2, 24'd9,  1'b1};
    tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 1'b1, 2'd3, 24'd12, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 2'd0, 24'd3,  1'b1};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd1, 24'd6,  1'b1};
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd2, 24'd9,  1'b1};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd3, 24'd12, 1'b1};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 24'd0,  1'b0};
    tbl[12] = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0, 24'd0,  1'b0};
    tbl[13] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 1'b0, 2'd0, 24'd0,  1'b1};
    tbl[14] = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 1'b0, 2'd0, 24'd0,  1'b1};
    tbl[15] = '{1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 24'd3,  1'b1};
    tbl[16] = '{1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 24'd3,  1'b1};
    tbl[17] = '{1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 24'd3,  1'b1};
    tbl[18] = '{1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 24'd3,  1'b1};
    tbl[19] = '{1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 24'd3,  1'b1};
    tbl[20] = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b1, 1'b1, 2'd0, 24'd3,  1'b1};
    tbl[21] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd1, 24'd6,  1'b1};
    tbl[22] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd2, 24'd9,  1'b1};
    tbl[23] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd3, 24'd12, 1'b1};
    tbl[24] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 24'd0,  1'b0};

    set_stream_operands();
    for (int i = 0; i < 25; i++) begin
      if (tbl[i].rst) do_reset();
      cyc(tbl[i].vld, tbl[i].rdy);
      chk($sformatf("row%0d req_ready", i), req_ready, tbl[i].e_ready);
      chk($sformatf("row%0d mul_ce", i), mul_ce, tbl[i].e_ce);
      chk($sformatf("row%0d res_valid", i), res_valid, tbl[i].e_rv);
      chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_rv) begin
        chk($sformatf("row%0d res_id", i), res_id, tbl[i].e_id);
        chk($sformatf("row%0d res_data", i), res_data, tbl[i].e_data);
      end
    end

    // ---- single request, full-scale operands ----
    do_reset();
    req_a = '0;
    req_b = '0;
    req_a[47:32] = 16'hFFFF;
    req_b[23:16] = 8'hFF;
    cyc(4'b0100, 1'b1);
    chk("single grant", req_ready, 4'b0100);
    chk("single din0", mul_din0, 16'hFFFF);
    chk("single din1", mul_din1, 8'hFF);
    cyc(4'b0000, 1'b1);
    chk("single c+1 res_valid", res_valid, 0);
    cyc(4'b0000, 1'b1);
    chk("single c+2 res_valid", res_valid, 0);
    cyc(4'b0000, 1'b1);
    chk("single c+3 res_valid", res_valid, 1);
    chk("single c+3 res_id", res_id, 2);
    chk("single c+3 res_data", res_data, 24'hFEFF01);
    cyc(4'b0000, 1'b1);
    chk("single after busy", busy, 0);
    chk("single after res_valid", res_valid, 0);

    // ---- fairness: req0 always valid, req3 joins at cycle 2 ----
    do_reset();
    set_stream_operands();
    cyc(4'b0001, 1'b1);
    chk("fair c0 grant", req_ready, 4'b0001);
    cyc(4'b0001, 1'b1);
    chk("fair c1 grant", req_ready, 4'b0001);
    got = -1;
    for (int k = 0; k < NREQ; k++) begin
      cyc(4'b1001, 1'b1);
      if (req_ready[3]) begin
        got = k;
        break;
      end
    end
    chk("fair req3 grant delay", got, 0);
    cyc(4'b1001, 1'b1);
    chk("fair wrap grant", req_ready, 4'b0001);
    chk("fair c3 res_id", res_id, 0);
    chk("fair c3 res_data", res_data, 3);
    cyc(4'b1001, 1'b1);
    chk("fair c4 grant", req_ready, 4'b1000);
    chk("fair c4 res_id", res_id, 0);
    cyc(4'b0000, 1'b1);
    chk("fair c5 res_valid", res_valid, 1);
    chk("fair c5 res_id", res_id, 3);
    chk("fair c5 res_data", res_data, 12);
    cyc(4'b0000, 1'b1);
    chk("fair c6 res_id", res_id, 0);
    cyc(4'b0000, 1'b1);
    chk("fair c7 res_id", res_id, 3);
    cyc(4'b0000, 1'b1);
    chk("fair c8 res_valid", res_valid, 0);

    // ---- reset mid-flight ----
    do_reset();
    set_stream_operands();
    cyc(4'b0111, 1'b1);
    chk("midrst grant0", req_ready, 4'b0001);
    cyc(4'b0110, 1'b1);
    chk("midrst grant1", req_ready, 4'b0010);
    cyc(4'b0100, 1'b1);
    chk("midrst grant2", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    res_ready = 1'b0;
    #1;
    chk("midrst pre res_valid", res_valid, 1);
    chk("midrst pre mul_ce", mul_ce, 0);
    reset = 1'b1;
    #1;
    chk("midrst async res_valid", res_valid, 0);
    chk("midrst async busy", busy, 0);
    chk("midrst async req_ready", req_ready, 0);
    chk("midrst async mul_ce", mul_ce, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(4'b0000, 1'b1);
      chk($sformatf("midrst quiet%0d res_valid", k), res_valid, 0);
    end
    req_a[31:16] = 16'h1234;
    req_b[15:8]  = 8'h38;
    cyc(4'b0010, 1'b1);
    chk("midrst new grant", req_ready, 4'b0010);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("midrst new c+2 res_valid", res_valid, 0);
    cyc(4'b0000, 1'b1);
    chk("midrst new res_valid", res_valid, 1);
    chk("midrst new res_id", res_id, 1);
    chk("midrst new res_data", res_data, 24'd260960);

    // ---- bubbles: req1 on/off ----
    do_reset();
    req_a = '0;
    req_b = '0;
    req_a[31:16] = 16'd100;
    req_b[15:8]  = 8'd200;
    rv_pat   = 9'b010101000;
    busy_pat = 9'b011111110;
    for (int k = 0; k < 9; k++) begin
      cyc((k < 6 && (k % 2) == 0) ? 4'b0010 : 4'b0000, 1'b1);
      if (k < 6 && (k % 2) == 0) chk($sformatf("bub c%0d grant", k), req_ready, 4'b0010);
      chk($sformatf("bub c%0d res_valid", k), res_valid, rv_pat[k]);
      chk($sformatf("bub c%0d busy", k), busy, busy_pat[k]);
      if (rv_pat[k]) begin
        chk($sformatf("bub c%0d res_id", k), res_id, 1);
        chk($sformatf("bub c%0d res_data", k), res_data, 24'h004E20);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
